alu_op_sequencer: RTL and testbench

//  Command-driven controller for the 8-bit ALU datapath (on / in_sel / num1 / num2 / out_sel -> out).

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_op_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: FSM state encodings,
// ALU in_sel control words, the illegal opcode and the opcode-to-one-hot map.
package alu_pkg;

    // Sequencer FSM states; the encoding is visible on the debug state port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_EXEC = 2'b10,
        ST_HOLD = 2'b11
    } state_e;

    // ALU in_sel control words, bit order {persist, load, reset}.
    localparam logic [2:0] IN_SEL_PERSIST = 3'b100;
    localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
    localparam logic [2:0] IN_SEL_RESET   = 3'b001;
    localparam logic [2:0] IN_SEL_NONE    = 3'b000;

    // Opcode that is rejected instead of being sent to the ALU.
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    // Widest one-hot select a 3-bit opcode can address.
    localparam int MAX_OPS = 8;

    // Opcode k selects one-hot bit (num_ops-1-k): op 0 is the MSB of the
    // select. Opcodes at or beyond num_ops give an all-zero select.
    function automatic logic [MAX_OPS-1:0] op_to_onehot(input logic [2:0] op,
                                                        input int       num_ops);
        logic [MAX_OPS-1:0] sel;
        sel = '0;
        if (int'(op) < num_ops) begin
            sel[num_ops - 1 - int'(op)] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Command-driven controller for the 8-bit ALU datapath. Accepts one command
// per valid/ready handshake, loads the operands into the ALU, holds the op
// for EXEC_CYCLES and captures the result, which is then offered on a second
// valid/ready handshake. This block is the only driver of the ALU controls.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int NUM_OPS     = 7,
    parameter int EXEC_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    // command channel
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic               cmd_chain,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    // result channel
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data,
    output logic [2:0]         res_op,
    output logic               err_op,
    // ALU control
    output logic               alu_on,
    output logic [2:0]         alu_in_sel,
    output logic [WIDTH-1:0]   alu_num1,
    output logic [WIDTH-1:0]   alu_num2,
    output logic [NUM_OPS-1:0] alu_out_sel,
    input  logic [WIDTH-1:0]   alu_out,
    // debug
    output logic [1:0]         state
);

    // Exec counter is at least one bit wide so EXEC_CYCLES=1 still elaborates.
    localparam int              CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   num1_q;
    logic [WIDTH-1:0]   num2_q;
    logic [WIDTH-1:0]   res_data_q;
    logic [2:0]         res_op_q;
    logic [WIDTH-1:0]   last_result_q;
    logic               err_op_q;

    logic               cmd_accept;
    logic               cmd_legal;
    logic               exec_last;
    logic               res_accept;

    assign cmd_accept = cmd_valid && (state_q == ST_IDLE);
    assign cmd_legal  = (cmd_op != OP_ILLEGAL);
    assign exec_last  = (cnt_q == CNT_LAST);
    assign res_accept = (state_q == ST_HOLD) && res_ready;

    // State register; reset returns to IDLE and abandons any command in flight.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> LOAD -> EXEC (EXEC_CYCLES) -> HOLD -> IDLE.
    // NOTE: state_d is defaulted first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                // An illegal opcode is consumed but the FSM stays put.
                if (cmd_accept && cmd_legal) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_last) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: handshake flags and ALU controls as a function of state.
    always_comb begin
        cmd_ready   = 1'b0;
        res_valid   = 1'b0;
        alu_on      = 1'b0;
        alu_in_sel  = IN_SEL_NONE;
        alu_out_sel = '0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            ST_LOAD: begin
                alu_on      = 1'b1;
                alu_in_sel  = IN_SEL_LOAD;
                alu_out_sel = NUM_OPS'(op_to_onehot(op_q, NUM_OPS));
            end
            ST_EXEC: begin
                alu_on      = 1'b1;
                alu_in_sel  = IN_SEL_PERSIST;
                alu_out_sel = NUM_OPS'(op_to_onehot(op_q, NUM_OPS));
            end
            ST_HOLD: begin
                res_valid = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // Datapath registers: operand latch, exec counter, result capture and the
    // illegal-opcode pulse. Everything here is cleared by reset, including the
    // chained-result register, so a chain after reset starts from zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q         <= '0;
            op_q          <= '0;
            num1_q        <= '0;
            num2_q        <= '0;
            res_data_q    <= '0;
            res_op_q      <= '0;
            last_result_q <= '0;
            err_op_q      <= 1'b0;
        end else begin
            // One-cycle pulse in the cycle after an illegal opcode is taken.
            err_op_q <= cmd_accept && !cmd_legal;

            // Operands are latched only for a legal command; otherwise the ALU
            // operand outputs keep their previous values.
            if (cmd_accept && cmd_legal) begin
                op_q   <= cmd_op;
                num1_q <= cmd_chain ? last_result_q : cmd_a;
                num2_q <= cmd_b;
            end

            // Count EXEC cycles; sample the ALU on the last one.
            if (state_q == ST_EXEC) begin
                if (exec_last) begin
                    cnt_q         <= '0;
                    res_data_q    <= alu_out;
                    last_result_q <= alu_out;
                    res_op_q      <= op_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign res_data = res_data_q;
    assign res_op   = res_op_q;
    assign err_op   = err_op_q;
    assign alu_num1 = num1_q;
    assign alu_num2 = num2_q;
    assign state    = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer. A table of commands with
// hand-computed results runs through the EXEC_CYCLES=1 instance; reset,
// backpressure, illegal-op and reset-during-EXEC sequences are hand-written,
// the last one on a second instance with EXEC_CYCLES=3.
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid, cmd_valid3;
    logic [2:0] cmd_op;
    logic       cmd_chain;
    logic [7:0] cmd_a, cmd_b;
    logic       res_ready, res_ready3;

    // Instance with EXEC_CYCLES = 1
    logic       cmd_ready, res_valid, err_op, alu_on;
    logic [7:0] res_data, alu_num1, alu_num2, alu_out;
    logic [2:0] res_op, alu_in_sel;
    logic [6:0] alu_out_sel;
    logic [1:0] state;

    // Instance with EXEC_CYCLES = 3
    logic       cmd_ready3, res_valid3, err_op3, alu_on3;
    logic [7:0] res_data3, alu_num1_3, alu_num2_3, alu_out3;
    logic [2:0] res_op3, alu_in_sel3;
    logic [6:0] alu_out_sel3;
    logic [1:0] state3;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(8), .NUM_OPS(7), .EXEC_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_chain(cmd_chain), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_op(res_op), .err_op(err_op),
        .alu_on(alu_on), .alu_in_sel(alu_in_sel), .alu_num1(alu_num1),
        .alu_num2(alu_num2), .alu_out_sel(alu_out_sel), .alu_out(alu_out),
        .state(state)
    );

    alu_op_sequencer #(.WIDTH(8), .NUM_OPS(7), .EXEC_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op),
        .cmd_chain(cmd_chain), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
        .res_op(res_op3), .err_op(err_op3),
        .alu_on(alu_on3), .alu_in_sel(alu_in_sel3), .alu_num1(alu_num1_3),
        .alu_num2(alu_num2_3), .alu_out_sel(alu_out_sel3), .alu_out(alu_out3),
        .state(state3)
    );

    // ALU stub: operands and select are registered on a load cycle; the
    // output is meaningful only while the ALU is enabled, zero otherwise.
    function automatic logic [7:0] alu_fn(input logic [6:0] sel, input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] r;
        case (sel)
            7'b1000000: r = a + b;
            7'b0100000: r = a - b;
            7'b0010000: r = a & b;
            7'b0001000: r = a | b;
            7'b0000100: r = a ^ b;
            7'b0000010: r = ~a;
            7'b0000001: r = a << 1;
            default:    r = 8'h00;
        endcase
        return r;
    endfunction

    logic [7:0] sa, sb, sa3, sb3;
    logic [6:0] ssel, ssel3;

    always @(posedge clk) begin
        if (alu_on && alu_in_sel == 3'b010) begin
            sa   <= alu_num1;
            sb   <= alu_num2;
            ssel <= alu_out_sel;
        end
        if (alu_on3 && alu_in_sel3 == 3'b010) begin
            sa3   <= alu_num1_3;
            sb3   <= alu_num2_3;
            ssel3 <= alu_out_sel3;
        end
    end

    assign alu_out  = alu_on  ? alu_fn(ssel, sa, sb)    : 8'h00;
    assign alu_out3 = alu_on3 ? alu_fn(ssel3, sa3, sb3) : 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic       chain;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] num1;   // operand the ALU must see
        logic [6:0] sel;    // one-hot select the ALU must see
        logic [7:0] data;   // captured result
        int         hold;   // cycles of res_ready=0 in HOLD
    } vec_t;

    // Full transaction on the EXEC_CYCLES=1 instance, called at a negedge.
    task automatic run_cmd(input string tag, input vec_t v);
        int lat;
        check({tag, ".cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_chain = v.chain;
        cmd_a     = v.a;
        cmd_b     = v.b;
        @(negedge clk);
        cmd_valid = 1'b0;
        // LOAD
        check({tag, ".load_state"}, state, 2'b01);
        check({tag, ".load_in_sel"}, alu_in_sel, 3'b010);
        check({tag, ".load_on"}, alu_on, 1);
        check({tag, ".load_out_sel"}, alu_out_sel, v.sel);
        check({tag, ".num1"}, alu_num1, v.num1);
        check({tag, ".num2"}, alu_num2, v.b);
        check({tag, ".busy_ready"}, cmd_ready, 0);
        @(negedge clk);
        // EXEC
        check({tag, ".exec_state"}, state, 2'b10);
        check({tag, ".exec_in_sel"}, alu_in_sel, 3'b100);
        check({tag, ".exec_out_sel"}, alu_out_sel, v.sel);
        lat = 2;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, 3);
        check({tag, ".res_data"}, res_data, v.data);
        check({tag, ".res_op"}, res_op, v.op);
        check({tag, ".hold_on"}, alu_on, 0);
        check({tag, ".hold_in_sel"}, alu_in_sel, 3'b000);
        check({tag, ".hold_out_sel"}, alu_out_sel, 7'b0);
        // Backpressure: a competing command must not be taken.
        for (int i = 0; i < v.hold; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 3'd1;
            cmd_chain = 1'b0;
            cmd_a     = 8'hEE;
            cmd_b     = 8'h11;
            @(negedge clk);
            check({tag, ".bp_valid"}, res_valid, 1);
            check({tag, ".bp_data"}, res_data, v.data);
            check({tag, ".bp_op"}, res_op, v.op);
            check({tag, ".bp_ready"}, cmd_ready, 0);
            check({tag, ".bp_state"}, state, 2'b11);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, ".done_state"}, state, 2'b00);
        check({tag, ".done_valid"}, res_valid, 0);
        @(negedge clk);
    endtask

    vec_t vecs[7];
    vec_t v6;

    initial begin
        int lat;
        int seen;

        vecs[0] = '{3'd0, 1'b0, 8'h57, 8'h1A, 8'h57, 7'b1000000, 8'h71, 0};
        vecs[1] = '{3'd0, 1'b1, 8'hFF, 8'h02, 8'h71, 7'b1000000, 8'h73, 0};
        vecs[2] = '{3'd1, 1'b0, 8'h50, 8'h20, 8'h50, 7'b0100000, 8'h30, 0};
        vecs[3] = '{3'd2, 1'b0, 8'hF0, 8'h3C, 8'hF0, 7'b0010000, 8'h30, 5};
        vecs[4] = '{3'd3, 1'b0, 8'hF0, 8'h0F, 8'hF0, 7'b0001000, 8'hFF, 0};
        vecs[5] = '{3'd4, 1'b1, 8'h00, 8'h0F, 8'hFF, 7'b0000100, 8'hF0, 0};
        vecs[6] = '{3'd5, 1'b0, 8'hA5, 8'h00, 8'hA5, 7'b0000010, 8'h5A, 0};

        // Reset held for two edges with a command pending.
        rst        = 1'b0;
        cmd_valid  = 1'b1;
        cmd_valid3 = 1'b1;
        cmd_op     = 3'd0;
        cmd_chain  = 1'b0;
        cmd_a      = 8'h12;
        cmd_b      = 8'h34;
        res_ready  = 1'b0;
        res_ready3 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.state", state, 2'b00);
        check("rst.res_valid", res_valid, 0);
        check("rst.err_op", err_op, 0);
        check("rst.alu_on", alu_on, 0);
        check("rst.in_sel", alu_in_sel, 3'b000);
        check("rst.out_sel", alu_out_sel, 7'b0);
        check("rst.num1", alu_num1, 8'h00);
        check("rst.num2", alu_num2, 8'h00);
        check("rst.res_data", res_data, 8'h00);
        check("rst.res_op", res_op, 3'd0);
        check("rst.state3", state3, 2'b00);
        cmd_valid  = 1'b0;
        cmd_valid3 = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        check("rst.cmd_ready", cmd_ready, 1);
        check("rst.idle", state, 2'b00);

        // Table of commands: basic op, chain, every opcode, backpressure.
        for (int i = 0; i < 7; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i]);
        end

        // Illegal opcode: one-cycle err_op, no ALU activity.
        check("ill.cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'd7;
        cmd_chain = 1'b0;
        cmd_a     = 8'h11;
        cmd_b     = 8'h22;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("ill.err_pulse", err_op, 1);
        check("ill.state", state, 2'b00);
        check("ill.alu_on", alu_on, 0);
        check("ill.res_valid", res_valid, 0);
        @(negedge clk);
        check("ill.err_clear", err_op, 0);
        check("ill.alu_on2", alu_on, 0);
        check("ill.res_valid2", res_valid, 0);
        check("ill.num1_held", alu_num1, 8'hA5);
        check("ill.num2_held", alu_num2, 8'h00);

        // Opcode 6 chained on the pre-illegal result (0x5A << 1).
        v6 = '{3'd6, 1'b1, 8'h77, 8'h00, 8'h5A, 7'b0000001, 8'hB4, 0};
        run_cmd("op6", v6);

        // EXEC_CYCLES=3: full transaction to check latency and leave a result.
        cmd_valid3 = 1'b1;
        cmd_op     = 3'd0;
        cmd_chain  = 1'b0;
        cmd_a      = 8'h05;
        cmd_b      = 8'h03;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        lat = 1;
        while (!res_valid3 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("e3.latency", lat, 5);
        check("e3.res_data", res_data3, 8'h08);
        res_ready3 = 1'b1;
        @(negedge clk);
        res_ready3 = 1'b0;
        check("e3.done_state", state3, 2'b00);

        // Reset during the second EXEC cycle aborts the command.
        cmd_valid3 = 1'b1;
        cmd_a      = 8'h10;
        cmd_b      = 8'h20;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        @(negedge clk);
        check("e3.exec1_state", state3, 2'b10);
        @(negedge clk);
        check("e3.exec2_state", state3, 2'b10);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("e3.abort_state", state3, 2'b00);
        check("e3.abort_on", alu_on3, 0);
        check("e3.abort_data", res_data3, 8'h00);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (res_valid3) seen++;
        end
        check("e3.no_result", seen, 0);

        // last_result was cleared: a chain now starts from zero.
        cmd_valid3 = 1'b1;
        cmd_op     = 3'd0;
        cmd_chain  = 1'b1;
        cmd_a      = 8'hFF;
        cmd_b      = 8'h04;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        check("e3.chain_num1", alu_num1_3, 8'h00);
        lat = 1;
        while (!res_valid3 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("e3.chain_latency", lat, 5);
        check("e3.chain_data", res_data3, 8'h04);
        res_ready3 = 1'b1;
        @(negedge clk);
        res_ready3 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
